result_drain: RTL and testbench
===============================

// Module: result_drain
// PURPOSE
//  Read-side counterpart of the result store. Pops {core_id, data} entries from
//    the shared result FIFO and presents them on a valid/ready output stream.
//  Counts drained results. Pulses done once the store reports finish and the
//    FIFO is empty.
//  Sits between the result FIFO and the host/memory writer.
// PARAMETERS
//  CORES       default 4   number of compute cores tagging results (power of 2, >=2)
//  DATA_WIDTH  default 32  result payload width
//  COUNT_WIDTH default 16  width of drained-result counter
//  CORE_COUNTER_WIDTH = log2(CORES); derived, taken from package
// PORTS
//  clk            in   1                     system clock
//  reset          in   1                     async, active-high reset
//  start          in   1                     pulse: begin a drain session (ignored unless idle)
//  store_finish   in   1                     result store has no more results (level or pulse)
//  fifo_empty     in   1                     result FIFO empty flag
//  fifo_rd_en     out  1                     FIFO pop; read data valid the following cycle
//  fifo_q         in   CORE_COUNTER_WIDTH+DATA_WIDTH  {core_id, data}
//  out_valid      out  1                     output entry valid
//  out_ready      in   1                     downstream accepts
//  out_core       out  CORE_COUNTER_WIDTH    originating core of output entry
//  out_data       out  DATA_WIDTH            result payload
//  busy           out  1                     session in progress (not S_Idle/S_Reset)
//  done           out  1                     one-cycle pulse at session end
//  result_count   out  COUNT_WIDTH           results accepted downstream this session
//  core_count     out  CORES*COUNT_WIDTH     per-core counts (only with RESULT_DRAIN_CORE_COUNT_EN)
// BEHAVIOUR
//  Reset: all outputs 0; state S_Reset; finish_seen 0. Async assert; mid-session reset discards any in-flight FIFO read data.
//  finish_seen: sticky; set by store_finish in any busy state; cleared on start.
//  FSM states (4-bit enum):
//    S_Reset   -> S_Idle after one cycle.
//    S_Idle    start=1: clear result_count, core_count and finish_seen -> S_Fetch.
//    S_Fetch   !fifo_empty: fifo_rd_en=1 -> S_Load.
//              fifo_empty && (finish_seen||store_finish): -> S_Finish.
//              Otherwise stay in S_Fetch.
//    S_Load    register fifo_q into out_core/out_data; out_valid=1 -> S_Present.
//    S_Present hold out_* stable while !out_ready.
//              On out_valid&&out_ready: result_count+1.
//              Then: !fifo_empty -> fifo_rd_en=1, S_Load (out_valid drops 1 cycle).
//              Otherwise -> S_Fetch, out_valid=0.
//    S_Finish  done=1 for one cycle -> S_Idle. result_count holds until next start.
//  Throughput: one entry per 2 cycles max. Pop-to-out_valid latency 2 cycles.
//  fifo_rd_en is asserted only when fifo_empty=0 in the same cycle. Never popped
//    while an entry is unaccepted.
//  Counter: result_count saturates at all-ones (no wrap).
//  Finish arriving with the FIFO non-empty: every entry drains first; done follows the last handshake.
//  start while busy: ignored. start and store_finish in the same idle cycle: finish_seen is set.
//  busy = state not in {S_Reset, S_Idle}.
// CONFIGURATION
//  RESULT_DRAIN_CORE_COUNT_EN defined:
//    - per-core saturating counters indexed by out_core, incremented on handshake.
//    - driven on core_count; core c occupies bits [c*COUNT_WIDTH +: COUNT_WIDTH].
//  Undefined: no counter bank; core_count tied to 0.
// STRUCTURE
//  Package pkg_resultDrain imports globalDefinitions (log2, cores).
//    - Defines CORE_COUNTER_WIDTH, CORES and STATES_t
//      {S_Reset,S_Idle,S_Fetch,S_Load,S_Present,S_Finish}.
//  One sub-module result_core_counter: a single saturating counter with clear/inc.
//    - Instantiated for result_count and, under the macro, CORES times in a generate loop.
// TESTING
//  1 Reset with FIFO holding 3 entries, no start -> fifo_rd_en never 1; all outputs 0.
//  2 start; FIFO {1,0xA},{3,0xB}; out_ready=1; finish after both -> two handshakes in order, result_count=2, one done pulse.
//  3 out_ready=0 for 5 cycles while out_valid -> out_core/out_data stable, no pop, count unchanged.
//  4 store_finish pulse while FIFO has 4 entries -> all 4 delivered before done; finish_seen cleared on next start.
//  5 COUNT_WIDTH=4, 20 results -> result_count saturates at 15.
//  6 Assert reset in S_Load -> out_valid=0 immediately; after release, state S_Idle; captured data dropped.
//  7 With RESULT_DRAIN_CORE_COUNT_EN, cores {0,2,2,3} -> core_count = {1,0,2,1} for cores 0..3.

Source files
------------

// File: rtl/result_drain_pkg.sv
// Shared types and constants for the result drain block.
// States are plain 4-bit constants so checkers can bind to them directly.
package result_drain_pkg;

  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int CORES              = 4;
  localparam int CORE_COUNTER_WIDTH = log2(CORES);

  typedef logic [3:0] states_t;

  localparam states_t S_RESET   = 4'd0;
  localparam states_t S_IDLE    = 4'd1;
  localparam states_t S_FETCH   = 4'd2;
  localparam states_t S_LOAD    = 4'd3;
  localparam states_t S_PRESENT = 4'd4;
  localparam states_t S_FINISH  = 4'd5;

endpackage

// File: rtl/result_drain_core_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module result_core_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/result_drain.sv
// Drains {core_id, data} entries from the result FIFO onto a valid/ready stream.
// Optional per-core counters are built when RESULT_DRAIN_CORE_COUNT_EN is defined.
module result_drain #(
  parameter int  CORES       = result_drain_pkg::CORES,
  parameter int  DATA_WIDTH  = 32,
  parameter int  COUNT_WIDTH = 16,
  localparam int CORE_W      = result_drain_pkg::log2(CORES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         store_finish,
  input  logic                         fifo_empty,
  output logic                         fifo_rd_en,
  input  logic [CORE_W+DATA_WIDTH-1:0] fifo_q,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CORE_W-1:0]            out_core,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         busy,
  output logic                         done,
  output logic [COUNT_WIDTH-1:0]       result_count,
  output logic [CORES*COUNT_WIDTH-1:0] core_count,
  output logic [3:0]                   dbg_state
);
  import result_drain_pkg::*;

  states_t                 state_q, state_d;
  logic                    finish_seen_q, finish_seen_d;
  logic                    out_valid_q, out_valid_d;
  logic [CORE_W-1:0]       out_core_q, out_core_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    rd_en;
  logic                    cnt_clr;
  logic                    hs;

  // Output stream: an entry transfers on any cycle where out_valid && out_ready;
  // out_core/out_data stay frozen while out_valid is high and out_ready is low.
  assign hs      = (state_q == S_PRESENT) && out_valid_q && out_ready;
  assign cnt_clr = (state_q == S_IDLE) && start;
  assign busy    = (state_q != S_RESET) && (state_q != S_IDLE);

  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q;
    out_core_d    = out_core_q;
    out_data_d    = out_data_q;
    rd_en         = 1'b0;
    finish_seen_d = finish_seen_q;

    if (cnt_clr) begin
      finish_seen_d = store_finish;
    end else if (busy && store_finish) begin
      finish_seen_d = 1'b1;
    end

    case (state_q)
      S_RESET: state_d = S_IDLE;
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (!fifo_empty) begin
          rd_en   = 1'b1;
          state_d = S_LOAD;
        end else if (finish_seen_q || store_finish) begin
          state_d = S_FINISH;
        end
      end
      S_LOAD: begin
        {out_core_d, out_data_d} = fifo_q;
        out_valid_d              = 1'b1;
        state_d                  = S_PRESENT;
      end
      S_PRESENT: begin
        // Next pop is issued only once the current entry has been accepted.
        if (hs) begin
          out_valid_d = 1'b0;
          if (!fifo_empty) begin
            rd_en   = 1'b1;
            state_d = S_LOAD;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_RESET;
      finish_seen_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_core_q    <= '0;
      out_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      finish_seen_q <= finish_seen_d;
      out_valid_q   <= out_valid_d;
      out_core_q    <= out_core_d;
      out_data_q    <= out_data_d;
    end
  end

  assign fifo_rd_en = rd_en;
  assign out_valid  = out_valid_q;
  assign out_core   = out_core_q;
  assign out_data   = out_data_q;
  assign done       = (state_q == S_FINISH);
  assign dbg_state  = state_q;

  result_core_counter #(.WIDTH(COUNT_WIDTH)) u_result_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr   (cnt_clr),
    .inc   (hs),
    .count (result_count)
  );

`ifdef RESULT_DRAIN_CORE_COUNT_EN
  for (genvar c = 0; c < CORES; c++) begin : g_core_cnt
    result_core_counter #(.WIDTH(COUNT_WIDTH)) u_core_cnt (
      .clk   (clk),
      .rst   (reset),
      .clr   (cnt_clr),
      .inc   (hs && (out_core_q == CORE_W'(c))),
      .count (core_count[c*COUNT_WIDTH +: COUNT_WIDTH])
    );
  end
`else
  assign core_count = '0;
`endif

endmodule

// File: tb/tb_result_drain.sv
// Randomized bench for result_drain: FIFO model, scoreboard and per-cycle monitor.
// Per-core expectations follow RESULT_DRAIN_CORE_COUNT_EN.
module tb_result_drain;
  import result_drain_pkg::*;

  localparam int CORES_T = 4;
  localparam int DW      = 32;
  localparam int CNTW    = 4;
  localparam int CW      = 2;
  localparam int W       = CW + DW;
  localparam int MAXC    = (1 << CNTW) - 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    start = 1'b0;
  logic                    store_finish = 1'b0;
  logic                    fifo_empty = 1'b1;
  logic                    fifo_rd_en;
  logic [W-1:0]            fifo_q = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [CW-1:0]           out_core;
  logic [DW-1:0]           out_data;
  logic                    busy;
  logic                    done;
  logic [CNTW-1:0]         result_count;
  logic [CORES_T*CNTW-1:0] core_count;
  logic [3:0]              dbg_state;

  result_drain #(.CORES(CORES_T), .DATA_WIDTH(DW), .COUNT_WIDTH(CNTW)) dut (
    .clk          (clk),
    .reset        (rst),
    .start        (start),
    .store_finish (store_finish),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_q       (fifo_q),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_core     (out_core),
    .out_data     (out_data),
    .busy         (busy),
    .done         (done),
    .result_count (result_count),
    .core_count   (core_count),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // FIFO model: pop registered at the clock edge, data presented the cycle after
  logic [W-1:0] fifo_mem[$];
  logic [W-1:0] exp_q[$];
  logic         rd_seen;

  always @(posedge clk or posedge rst) begin
    if (rst) rd_seen <= 1'b0;
    else     rd_seen <= fifo_rd_en;
  end

  always @(negedge clk) begin
    if (rd_seen && fifo_mem.size() > 0) fifo_q = fifo_mem.pop_front();
    fifo_empty = (fifo_mem.size() == 0);
  end

  task automatic push_entry(input logic [CW-1:0] core, input logic [DW-1:0] data);
    fifo_mem.push_back({core, data});
    exp_q.push_back({core, data});
  endtask

  task automatic flush_all();
    fifo_mem.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
  endtask

  // reference model and monitor, sampled 2 time units before each rising edge
  int   model_cnt;
  int   model_core[CORES_T];
  int   done_cnt = 0;
  bit   prev_stall = 0;
  bit   prev_done = 0;
  logic [CW-1:0] held_core;
  logic [DW-1:0] held_data;

  always @(negedge clk) begin
    logic [W-1:0] e;
    int           exp_cc;
    int           ci;
    #3;
    if (rst) begin
      check("rst_valid", out_valid, 0);
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_count", result_count, 0);
      check("rst_core_count", core_count, 0);
      model_cnt  = 0;
      for (int c = 0; c < CORES_T; c++) model_core[c] = 0;
      prev_stall = 0;
      prev_done  = 0;
    end else begin
      check("pop_empty", fifo_rd_en & fifo_empty, 0);
      if (!busy) check("idle_pop", fifo_rd_en, 0);
      check("result_count", result_count, model_cnt);
      for (int c = 0; c < CORES_T; c++) begin
`ifdef RESULT_DRAIN_CORE_COUNT_EN
        exp_cc = model_core[c];
`else
        exp_cc = 0;
`endif
        check("core_count", core_count[c*CNTW +: CNTW], exp_cc);
      end
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_core", out_core, held_core);
        check("hold_data", out_data, held_data);
      end
      if (out_valid && !out_ready) check("stall_pop", fifo_rd_en, 0);
      prev_stall = out_valid && !out_ready;
      held_core  = out_core;
      held_data  = out_data;
      if (out_valid && out_ready) begin
        check("exp_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_entry", {out_core, out_data}, e);
          ci = int'(e[W-1:DW]);
          if (model_cnt < MAXC) model_cnt++;
          if (model_core[ci] < MAXC) model_core[ci]++;
        end
      end
      if (done) begin
        check("done_drained", exp_q.size(), 0);
        check("done_pulse", prev_done, 0);
        done_cnt++;
      end
      prev_done = done;
      if (start && !busy) begin
        model_cnt = 0;
        for (int c = 0; c < CORES_T; c++) model_core[c] = 0;
      end
    end
  end

  // driver tasks
  task automatic pulse_start(input bit with_finish);
    @(negedge clk);
    start        = 1'b1;
    store_finish = with_finish;
    @(negedge clk);
    start        = 1'b0;
    store_finish = 1'b0;
  endtask

  // finish_at < 0: raise store_finish once every pushed entry has been delivered
  task automatic drive_until_done(input int ready_pct, input int finish_at);
    int d0;
    int cyc;
    bit fin_sent;
    d0       = done_cnt;
    cyc      = 0;
    fin_sent = 0;
    while (done_cnt == d0 && cyc < 600) begin
      @(negedge clk);
      out_ready    = ($urandom_range(99) < ready_pct);
      store_finish = 1'b0;
      if (!fin_sent && ((finish_at >= 0 && cyc >= finish_at) ||
                        (finish_at < 0 && exp_q.size() == 0))) begin
        store_finish = 1'b1;
        fin_sent     = 1;
      end
      cyc++;
    end
    @(negedge clk);
    store_finish = 1'b0;
    out_ready    = 1'b0;
    check("session_done", done_cnt, d0 + 1);
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++)
      push_entry(CW'($urandom_range(CORES_T - 1)), DW'($urandom));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int w;
    int d0;
    int exp_cc;
    #1 rst = 1'b1;

    // reset held with a populated FIFO and no start
    push_random(3);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t1_rd_en", fifo_rd_en, 0);
    check("t1_valid", out_valid, 0);
    check("t1_busy", busy, 0);
    check("t1_state", dbg_state, S_IDLE);
    check("t1_fifo_kept", fifo_mem.size(), 3);
    flush_all();

    // two entries delivered in order, single done
    push_entry(2'd1, 32'hA);
    push_entry(2'd3, 32'hB);
    @(negedge clk);
    pulse_start(0);
    drive_until_done(100, -1);
    check("t2_count", result_count, 2);
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    check("t2_one_done", done_cnt, d0);

    // back-pressure: held output, no pop, count unchanged
    push_entry(2'd2, DW'($urandom));
    @(negedge clk);
    out_ready = 1'b0;
    pulse_start(0);
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("t3_valid_up", out_valid, 1);
    push_random(2);
    repeat (5) @(negedge clk);
    check("t3_count", result_count, 0);
    check("t3_fifo_kept", fifo_mem.size(), 2);
    drive_until_done(100, -1);
    check("t3_final", result_count, 3);

    // finish while four entries are still queued
    push_random(4);
    @(negedge clk);
    pulse_start(0);
    drive_until_done(60, 0);
    check("t4_count", result_count, 4);
    d0 = done_cnt;
    pulse_start(0);
    repeat (10) @(negedge clk);
    check("t4_seen_cleared", busy, 1);
    check("t4_no_done", done_cnt, d0);
    push_random(1);
    drive_until_done(100, -1);

    // counter saturation
    push_random(20);
    @(negedge clk);
    pulse_start(0);
    drive_until_done(100, 3);
    check("t5_saturate", result_count, MAXC);

    // reset while loading
    out_ready = 1'b0;
    push_random(2);
    repeat (2) @(negedge clk);
    pulse_start(0);
    @(negedge clk);
    check("t6_in_load", dbg_state, S_LOAD);
    rst = 1'b1;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_state_rst", dbg_state, S_RESET);
    @(negedge clk);
    flush_all();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_state_idle", dbg_state, S_IDLE);
    check("t6_data_dropped", out_data, 0);
    check("t6_valid_after", out_valid, 0);

    // per-core accounting
    push_entry(2'd0, DW'($urandom));
    push_entry(2'd2, DW'($urandom));
    push_entry(2'd2, DW'($urandom));
    push_entry(2'd3, DW'($urandom));
    @(negedge clk);
    pulse_start(0);
    drive_until_done(100, -1);
    for (int c = 0; c < CORES_T; c++) begin
`ifdef RESULT_DRAIN_CORE_COUNT_EN
      exp_cc = (c == 0) ? 1 : (c == 1) ? 0 : (c == 2) ? 2 : 1;
`else
      exp_cc = 0;
`endif
      check("t7_core_count", core_count[c*CNTW +: CNTW], exp_cc);
    end

    // randomized sessions
    for (int s = 0; s < 8; s++) begin
      push_random($urandom_range(8, 1));
      @(negedge clk);
      pulse_start(1'($urandom_range(1)));
      drive_until_done($urandom_range(100, 30), int'($urandom_range(20)) - 1);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
